// File: rtl/dp_unpack4.sv
// Sequential 1-to-4 word unpacker: collects serial words over valid/ready and
// presents them as a registered 4-operand bundle, with FLUSH padding partial bundles.
module dp_unpack4 #(
  parameter int          N   = 8,
  parameter logic [N-1:0] PAD = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din_i,
  input  logic         din_valid_i,
  output logic         din_ready_o,
  input  logic         flush_i,
  output logic [N-1:0] out0_o,
  output logic [N-1:0] out1_o,
  output logic [N-1:0] out2_o,
  output logic [N-1:0] out3_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [1:0]   cnt_o
);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [3:0][N-1:0]   slot_q, slot_d;
  logic                inXfer;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    out_valid_o = (state_q == HOLD);
    din_ready_o = (state_q == COLLECT) | out_ready_i;
    inXfer      = din_valid_i & din_ready_o;

    case (state_q)
      COLLECT: begin
        if (inXfer) begin
          slot_d[cnt_q] = din_i;
          if (cnt_q == 2'd3) begin
            state_d = HOLD;
            cnt_d   = 2'd0;
          end else if (flush_i) begin
            // The word accepted now lands in slot cnt_q; only higher slots get PAD.
            for (int i = 0; i < 4; i++) begin
              if (i > int'(cnt_q)) slot_d[i] = PAD;
            end
            state_d = HOLD;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (flush_i && (cnt_q != 2'd0)) begin
          for (int i = 0; i < 4; i++) begin
            if (i >= int'(cnt_q)) slot_d[i] = PAD;
          end
          state_d = HOLD;
          cnt_d   = 2'd0;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = COLLECT;
          // Bypass: a word arriving with the output transfer starts the next bundle.
          if (din_valid_i) begin
            slot_d[0] = din_i;
            cnt_d     = 2'd1;
          end else begin
            cnt_d = 2'd0;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= 2'd0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

  assign out0_o = slot_q[0];
  assign out1_o = slot_q[1];
  assign out2_o = slot_q[2];
  assign out3_o = slot_q[3];
  assign cnt_o  = cnt_q;

endmodule

// File: tb/tb_dp_unpack4.sv
// Scoreboard bench for dp_unpack4: a word-list reference model predicts bundles
// into a queue; an independent monitor pops and compares each presented bundle.
module tb_dp_unpack4;

   localparam int N = 8;
   localparam logic [7:0] PADV = 8'hFF;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] din;
   logic         dinValid;
   logic         dinReady;
   logic         flush;
   logic [N-1:0] out0, out1, out2, out3;
   logic         outValid;
   logic         outReady;
   logic [1:0]   cnt;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: words accepted into the open bundle, and whether
   // a closed bundle is waiting for the consumer.
   logic [7:0]  partial[$];
   logic [31:0] expQ[$];
   bit          pending = 0;
   bit          lastAccepted = 0;

   dp_unpack4 #(.N(N), .PAD(PADV)) dut (
      .clk(clk), .rst_n(rst_n),
      .din_i(din), .din_valid_i(dinValid), .din_ready_o(dinReady),
      .flush_i(flush),
      .out0_o(out0), .out1_o(out1), .out2_o(out2), .out3_o(out3),
      .out_valid_o(outValid), .out_ready_i(outReady), .cnt_o(cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Close the open bundle: pad missing slots, first word into OUT0.
   task automatic emitBundle();
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < 4; i++)
         b[31-8*i -: 8] = (i < partial.size()) ? partial[i] : PADV;
      expQ.push_back(b);
      partial.delete();
      pending = 1;
   endtask

   // Model process: checks handshake/count signals against the model, then
   // advances the model as if the coming rising edge had happened.
   always @(negedge clk) begin
      if (rst_n) begin
         bit expReady, wasHold, outX, inX;
         wasHold  = pending;
         expReady = !pending || outReady;
         checkOutput("din_ready", {31'd0, dinReady}, {31'd0, expReady});
         checkOutput("out_valid", {31'd0, outValid}, {31'd0, pending});
         checkOutput("cnt", {30'd0, cnt}, 32'(partial.size()));
         outX = pending && outReady;
         inX  = dinValid && expReady;
         if (outX) pending = 0;
         if (inX) partial.push_back(din);
         if (partial.size() == 4)
            emitBundle();
         else if (!wasHold && flush && partial.size() > 0)
            emitBundle();
         lastAccepted = inX;
      end
   end

   // Monitor process: compares whatever bundle the DUT presents against the
   // scoreboard front, retiring it when the consumer takes it.
   always @(negedge clk) begin
      if (rst_n && outValid) begin
         if (expQ.size() == 0) begin
            checkOutput("bundle_unexpected", {out0, out1, out2, out3}, 32'hxxxxxxxx);
         end else begin
            checkOutput("bundle", {out0, out1, out2, out3}, expQ[0]);
            if (outReady) void'(expQ.pop_front());
         end
      end
   end

   task automatic applyStimulus(input bit v, input logic [7:0] d, input bit f, input bit r);
      dinValid = v;
      din      = d;
      flush    = f;
      outReady = r;
      @(posedge clk);
      #1;
   endtask

   task automatic sendWord(input logic [7:0] d, input bit f, input bit randReady, input bit r);
      int tries;
      tries = 0;
      do begin
         applyStimulus(1, d, f, randReady ? 1'($urandom_range(0, 1)) : r);
         tries++;
      end while (!lastAccepted && tries < 50);
      if (!lastAccepted) checkOutput("accept_timeout", 32'(tries), 32'd0);
   endtask

   task automatic applyReset();
      dinValid = 0; flush = 0; outReady = 0; din = '0;
      rst_n = 0;
      partial.delete(); expQ.delete(); pending = 0; lastAccepted = 0;
      #1;
      checkOutput("rst_bundle", {out0, out1, out2, out3}, 32'd0);
      checkOutput("rst_valid", {31'd0, outValid}, 32'd0);
      checkOutput("rst_cnt", {30'd0, cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((pending || expQ.size() != 0) && n < 20) begin
         applyStimulus(0, 8'h00, 0, 1);
         n++;
      end
      checkOutput("drain", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      rst_n = 0; dinValid = 0; din = '0; flush = 0; outReady = 0;
      repeat (2) @(posedge clk);
      #1;
      applyReset();

      // Fill with consumer stalled, then hold five cycles before releasing.
      sendWord(8'h11, 0, 0, 0);
      sendWord(8'h22, 0, 0, 0);
      sendWord(8'h33, 0, 0, 0);
      sendWord(8'h44, 0, 0, 0);
      checkOutput("fill_bundle", {out0, out1, out2, out3}, 32'h11223344);
      repeat (5) applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 0, 1);

      // Asynchronous reset with two words in the open bundle.
      sendWord(8'hAB, 0, 0, 0);
      sendWord(8'hCD, 0, 0, 0);
      #2;
      applyReset();

      // Back-to-back streaming with both sides always ready.
      for (int i = 1; i <= 8; i++) sendWord(8'(i), 0, 0, 1);
      drain();

      // Partial bundle closed by FLUSH alone.
      sendWord(8'hA5, 0, 0, 0);
      sendWord(8'h5A, 0, 0, 0);
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("flush_partial", {out0, out1, out2, out3}, 32'hA55AFFFF);
      drain();

      // FLUSH corners: empty, with the third word, and while holding.
      applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 0, 0);
      sendWord(8'h10, 0, 0, 0);
      sendWord(8'h20, 0, 0, 0);
      sendWord(8'h77, 1, 0, 0);
      checkOutput("flush_third", {out0, out1, out2, out3}, 32'h102077FF);
      repeat (2) applyStimulus(0, 8'h00, 1, 0);
      drain();

      // FLUSH coinciding with a fourth word closes a normal bundle.
      for (int i = 0; i < 3; i++) sendWord(8'hC0 + 8'(i), 0, 0, 0);
      sendWord(8'hC3, 1, 0, 0);
      drain();

      // Random traffic with toggling backpressure and occasional flushes.
      for (int i = 0; i < 200; i++) begin
         sendWord(8'($urandom), ($urandom_range(0, 7) == 0), 1, 0);
         if ($urandom_range(0, 3) == 0) applyStimulus(0, 8'h00, 0, 1'($urandom_range(0, 1)));
      end
      applyStimulus(0, 8'h00, 1, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
